// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: access codes, FSM states,
// default timeout and the legality/alignment check applied at acceptance.
package mem_pkg;

    localparam logic [3:0] BE_WORD    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF    = 4'b0010;
    localparam logic [3:0] BE_HALF_ST = 4'b0011;
    localparam logic [3:0] BE_SBYTE   = 4'b0100;
    localparam logic [3:0] BE_SHALF   = 4'b1000;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // True when {memw,be} is a legal code and the address suits its access width.
    function automatic logic access_ok(input logic memw, input logic [3:0] be,
                                       input logic [1:0] lo);
        logic ok;
        case ({memw, be})
            {1'b0, BE_WORD}, {1'b1, BE_WORD}:                    ok = (lo == 2'b00);
            {1'b0, BE_BYTE}, {1'b1, BE_BYTE}, {1'b0, BE_SBYTE}:  ok = 1'b1;
            {1'b0, BE_HALF}, {1'b1, BE_HALF_ST}, {1'b0, BE_SHALF}: ok = !lo[0];
            default:                                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/subword_align.sv
// Little-endian lane handling: extracts/extends a load lane and merges a
// sub-word store into the word read back from memory.
module subword_align
    import mem_pkg::*;
(
    input  logic        memw,
    input  logic [3:0]  be,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] store,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic        is_byte;
    logic        is_half;
    logic        is_signed;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        is_byte   = (be == BE_BYTE) || (!memw && be == BE_SBYTE);
        is_half   = memw ? (be == BE_HALF_ST) : (be == BE_HALF || be == BE_SHALF);
        is_signed = !memw && (be == BE_SBYTE || be == BE_SHALF);
        byte_lane = word[{lane, 3'b000} +: 8];
        half_lane = word[{lane[1], 4'b0000} +: 16];

        load_data = word;
        if (is_byte)
            load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
        else if (is_half)
            load_data = {{16{is_signed & half_lane[15]}}, half_lane};

        // Full-word stores pass straight through; sub-word stores overlay one lane.
        merge_data = store;
        if (is_byte) begin
            merge_data = word;
            merge_data[{lane, 3'b000} +: 8] = store[7:0];
        end else if (is_half) begin
            merge_data = word;
            merge_data[{lane[1], 4'b0000} +: 16] = store[15:0];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Processor-side load/store controller: decodes the access, runs the memory
// handshake (with read-modify-write for sub-word stores) and times out stalls.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemW,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic          memw_reg;
    logic [3:0]    be_reg;
    logic [31:0]   load_data;
    logic [31:0]   merge_data;

    subword_align u_align (
        .memw       (memw_reg),
        .be         (be_reg),
        .lane       (addr_reg[1:0]),
        .word       (mem_rdata),
        .store      (wdata_reg),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign mem_addr = {addr_reg[31:2], 2'b00};
    assign busy     = (state != IDLE) || (start && reset);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            memw_reg  <= 1'b0;
            be_reg    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= '0;
            mem_wdata <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        memw_reg  <= MemW;
                        be_reg    <= be;
                        if (!access_ok(MemW, be, addr[1:0])) begin
                            state <= ERR;
                            fault <= 1'b1;
                        end else if (!MemW) begin
                            state   <= RD;
                            mem_req <= 1'b1;
                        end else if (be == BE_WORD) begin
                            state     <= WR;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state   <= RMW_RD;
                            mem_req <= 1'b1;
                        end
                    end
                end
                RD, RMW_RD, WR: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (mem_ack) begin
                        cnt <= '0;
                        if (state == RMW_RD) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= merge_data;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            if (state == RD)
                                rdata <= load_data;
                        end
                    end else if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        state   <= ERR;
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Table-driven bench for mem_access_ctrl with a wait-state memory model and a
// scoreboard of expected completions.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        MemW = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MemW      (MemW),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    typedef struct packed {
        logic        memw;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          ack_wait;
        bit          repulse;
        bit          exp_fault;
        int          exp_lat;
        int          exp_req;
        bit          is_load;
        logic [31:0] exp_rdata;
        bit          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct packed {
        bit          fault;
        int          lat;
        int          req;
        logic [31:0] rdata;
        int          wr_count;
        logic [31:0] wdata;
        logic [31:0] waddr;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          ack_wait = 0;
    int          wcnt = 0;
    int          req_cycles = 0;
    int          wr_count = 0;
    logic [31:0] wr_data = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] model_rdata = '0;
    exp_t        sb[$];
    vec_t        vecs[17];

    // Memory model: acks after ack_wait request cycles per phase, never if negative.
    always @(negedge clk) begin
        if (!mem_req || mem_ack) wcnt = 0;
        if (mem_req) begin
            mem_ack = (ack_wait >= 0) && (wcnt == ack_wait);
            wcnt++;
            req_cycles++;
            if (mem_we && mem_ack) begin
                wr_count++;
                wr_data = mem_wdata;
                wr_addr = mem_addr;
            end
        end else begin
            mem_ack = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic memw, logic [3:0] b, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] word, int aw, bit rep, bit ef, int lat, int req,
                                bit ld, logic [31:0] erd, bit ewr, logic [31:0] ewd);
        vec_t v;
        v.memw = memw;   v.be = b;          v.addr = a;        v.wdata = wd;
        v.word = word;   v.ack_wait = aw;   v.repulse = rep;   v.exp_fault = ef;
        v.exp_lat = lat; v.exp_req = req;   v.is_load = ld;    v.exp_rdata = erd;
        v.exp_wr = ewr;  v.exp_wdata = ewd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        @(negedge clk);
        req_cycles = 0;
        wr_count   = 0;
        ack_wait   = v.ack_wait;
        mem_rdata  = v.word;
        MemW = v.memw; be = v.be; addr = v.addr; wdata = v.wdata; start = 1'b1;
        e.fault    = v.exp_fault;
        e.lat      = v.exp_lat;
        e.req      = v.exp_req;
        e.rdata    = (v.is_load && !v.exp_fault) ? v.exp_rdata : model_rdata;
        e.wr_count = v.exp_wr ? 1 : 0;
        e.wdata    = v.exp_wdata;
        e.waddr    = {v.addr[31:2], 2'b00};
        model_rdata = e.rdata;
        sb.push_back(e);
        #1 check("busy_on_start", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        MemW = ~v.memw; be = ~v.be; addr = ~v.addr; wdata = ~v.wdata;
        lat  = 1;
        seen = 0;
        while (!seen && lat <= 40) begin
            if (done || fault) begin
                seen = 1;
            end else begin
                start = (v.repulse && lat == 2);
                @(posedge clk);
                #1;
                lat++;
            end
        end
        start = 1'b0;
        got = sb.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL no_response vec %0d: got none expected done/fault", idx);
        end else begin
            check("fault_flag", {31'b0, fault}, {31'b0, got.fault});
            check("done_flag", {31'b0, done}, {31'b0, !got.fault});
            check("latency", lat, got.lat);
            check("rdata", rdata, got.rdata);
            check("req_cycles", req_cycles, got.req);
            check("write_count", wr_count, got.wr_count);
            if (got.wr_count != 0) begin
                check("mem_wdata", wr_data, got.wdata);
                check("mem_addr", wr_addr, got.waddr);
            end
            @(posedge clk);
            #1;
            check("pulse_end", {30'b0, done, fault}, 32'd0);
            check("back_idle", {31'b0, busy}, 32'd0);
        end
        $display("txn %0d: memw=%0d be=%b addr=%h lat=%0d fault=%0d rdata=%h writes=%0d wdata=%h",
                 idx, v.memw, v.be, v.addr, lat, got.fault, rdata, wr_count, wr_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, BE_SBYTE,   32'h103, 32'h0,        32'h80FF_1234, 0, 0, 0, 2, 1, 1, 32'hFFFF_FF80, 0, 0);
        vecs[1]  = mk(1, BE_BYTE,    32'h201, 32'hDEAD_BEAB, 32'h1122_3344, 0, 0, 0, 3, 2, 0, 0, 1, 32'h1122_AB44);
        vecs[2]  = mk(0, BE_HALF,    32'h003, 32'h0,        32'h0,          0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, BE_WORD,    32'h010, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 2, 1, 1, 32'hCAFE_F00D, 0, 0);
        vecs[4]  = mk(0, BE_BYTE,    32'h022, 32'h0,        32'h1234_5678, 0, 0, 0, 2, 1, 1, 32'h0000_0034, 0, 0);
        vecs[5]  = mk(0, BE_HALF,    32'h032, 32'h0,        32'h89AB_4567, 0, 0, 0, 2, 1, 1, 32'h0000_89AB, 0, 0);
        vecs[6]  = mk(0, BE_SHALF,   32'h040, 32'h0,        32'h1234_8001, 0, 0, 0, 2, 1, 1, 32'hFFFF_8001, 0, 0);
        vecs[7]  = mk(1, BE_HALF_ST, 32'h052, 32'h1234_BEEF, 32'h1122_3344, 0, 0, 0, 3, 2, 0, 0, 1, 32'hBEEF_3344);
        vecs[8]  = mk(1, BE_WORD,    32'h060, 32'h55AA_55AA, 32'h0,         0, 0, 0, 2, 1, 0, 0, 1, 32'h55AA_55AA);
        vecs[9]  = mk(1, BE_HALF,    32'h000, 32'h0,        32'h0,          0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, BE_WORD,    32'h062, 32'h1,        32'h0,          0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, BE_SBYTE,   32'h100, 32'h0,        32'h0000_007F, 0, 0, 0, 2, 1, 1, 32'h0000_007F, 0, 0);
        vecs[12] = mk(1, BE_WORD,    32'h080, 32'h0BAD_CAFE, 32'h0,         3, 1, 0, 5, 4, 0, 0, 1, 32'h0BAD_CAFE);
        vecs[13] = mk(0, BE_WORD,    32'h070, 32'h0,        32'h1234_5678, -1, 0, 1, 16, 15, 0, 0, 0, 0);
        vecs[14] = mk(0, BE_SHALF,   32'h041, 32'h0,        32'h0,          0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 4'b0011,    32'h000, 32'h0,        32'h0,          0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, BE_BYTE,    32'h203, 32'h0000_00CD, 32'h1122_3344, 0, 0, 0, 3, 2, 0, 0, 1, 32'hCD22_3344);

        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {27'b0, busy, done, fault, mem_req, mem_we}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Reset while waiting in the read phase of a byte store.
        begin
            int stray;
            @(negedge clk);
            ack_wait = -1;
            MemW = 1'b1; be = BE_BYTE; addr = 32'h205; wdata = 32'h77; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            check("rmw_req_active", {31'b0, mem_req}, 32'd1);
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            #1;
            check("rst_mid_flags", {28'b0, busy, done, fault, mem_req}, 32'd0);
            model_rdata = '0;
            check("rst_mid_rdata", rdata, model_rdata);
            @(negedge clk);
            reset = 1'b1;
            stray = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (done || fault || mem_req) stray++;
            end
            check("rst_mid_no_pulse", stray, 32'd0);
            $display("txn reset_mid_rmw: mem_req=%0d busy=%0d stray=%0d", mem_req, busy, stray);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
